// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for the RV32I core.
// Handles memory ready handshakes, variable EXECUTE latency, bus timeout, stall and trap.
//
// state     | meaning
// ----------+------------------------------------------------------------
// FETCH     | imem request outstanding, latch IR on imem_ready
// DECODE    | latch opcode, classify, load execute counter
// EXECUTE   | count down execute latency, then dispatch on opcode
// MEMORY    | dmem request outstanding (load or store)
// WRITEBACK | one-cycle register-file write, PC update and retire
// TRAP      | illegal/SYSTEM opcode or bus timeout, wait for trap_clear
module multicycle_ctrl_fsm #(
   parameter int EXEC_CYCLES = 1,
   parameter int MUL_CYCLES  = 4,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       opcode_i,
   input  logic             is_mul_i,
   output logic             imem_req_o,
   input  logic             imem_ready_i,
   output logic             dmem_req_o,
   output logic             dmem_we_o,
   input  logic             dmem_ready_i,
   input  logic             stall_i,
   input  logic             trap_clear_i,
   output logic             ir_we_o,
   output logic             pc_we_o,
   output logic             rf_we_o,
   output logic             retire_o,
   output logic             trap_o,
   output logic [1:0]       trap_cause_o,
   output logic [2:0]       current_state_o,
   output logic [CNT_W-1:0] instret_o
);

   typedef enum logic [2:0] {
      FETCH     = 3'd0,
      DECODE    = 3'd1,
      EXECUTE   = 3'd2,
      MEMORY    = 3'd3,
      WRITEBACK = 3'd4,
      TRAP      = 3'd5
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   // Counters only need to hold "cycles - 1", so clog2 of the cycle count suffices.
   localparam int MAXC = (MUL_CYCLES > EXEC_CYCLES) ? MUL_CYCLES : EXEC_CYCLES;
   localparam int EXW  = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam int WTW  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   localparam logic [EXW-1:0] EXEC_LOAD = EXW'(EXEC_CYCLES - 1);
   localparam logic [EXW-1:0] MUL_LOAD  = EXW'(MUL_CYCLES - 1);
   localparam logic [WTW-1:0] WAIT_LAST = WTW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   state_t           state_q, state_d;
   logic [EXW-1:0]   exec_q, exec_d;
   logic [WTW-1:0]   wait_q, wait_d;
   logic [6:0]       op_q, op_d;
   logic [1:0]       cause_q, cause_d;
   logic [CNT_W-1:0] instret_q;
   logic             timeout_hit;

   assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FETCH;
         exec_q    <= '0;
         wait_q    <= '0;
         op_q      <= '0;
         cause_q   <= '0;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         exec_q  <= exec_d;
         wait_q  <= wait_d;
         op_q    <= op_d;
         cause_q <= cause_d;
         if (retire_o) instret_q <= instret_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d    = state_q;
      exec_d     = exec_q;
      wait_d     = '0;
      op_d       = op_q;
      cause_d    = cause_q;
      imem_req_o = 1'b0;
      dmem_req_o = 1'b0;
      dmem_we_o  = 1'b0;
      ir_we_o    = 1'b0;
      pc_we_o    = 1'b0;
      rf_we_o    = 1'b0;
      retire_o   = 1'b0;
      trap_o     = 1'b0;

      case (state_q)
         FETCH: begin
            imem_req_o = 1'b1;
            if (stall_i) begin
               wait_d = wait_q;
            end else if (imem_ready_i) begin
               ir_we_o = 1'b1;
               state_d = DECODE;
            end else if (timeout_hit) begin
               state_d = TRAP;
               cause_d = 2'd2;
            end else begin
               wait_d = wait_q + WTW'(1);
            end
         end
         DECODE: begin
            if (!stall_i) begin
               op_d = opcode_i;
               case (opcode_i)
                  OP_LOAD, OP_STORE, OP_BRANCH, OP_OP, OP_OPIMM,
                  OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_FENCE: begin
                     state_d = EXECUTE;
                     exec_d  = is_mul_i ? MUL_LOAD : EXEC_LOAD;
                  end
                  OP_SYSTEM: begin
                     state_d = TRAP;
                     cause_d = 2'd1;
                  end
                  default: begin
                     state_d = TRAP;
                     cause_d = 2'd0;
                  end
               endcase
            end
         end
         EXECUTE: begin
            if (!stall_i) begin
               if (exec_q != '0) begin
                  exec_d = exec_q - EXW'(1);
               end else begin
                  case (op_q)
                     OP_BRANCH, OP_FENCE: begin
                        pc_we_o  = 1'b1;
                        retire_o = 1'b1;
                        state_d  = FETCH;
                     end
                     OP_LOAD, OP_STORE: state_d = MEMORY;
                     default:           state_d = WRITEBACK;
                  endcase
               end
            end
         end
         MEMORY: begin
            dmem_req_o = 1'b1;
            dmem_we_o  = (op_q == OP_STORE);
            if (stall_i) begin
               wait_d = wait_q;
            end else if (dmem_ready_i) begin
               if (op_q == OP_STORE) begin
                  pc_we_o  = 1'b1;
                  retire_o = 1'b1;
                  state_d  = FETCH;
               end else begin
                  state_d = WRITEBACK;
               end
            end else if (timeout_hit) begin
               state_d = TRAP;
               cause_d = 2'd2;
            end else begin
               wait_d = wait_q + WTW'(1);
            end
         end
         WRITEBACK: begin
            if (!stall_i) begin
               rf_we_o  = 1'b1;
               pc_we_o  = 1'b1;
               retire_o = 1'b1;
               state_d  = FETCH;
            end
         end
         TRAP: begin
            trap_o = 1'b1;
            // Clear is honoured even under stall so a frozen core can always be recovered.
            if (trap_clear_i) begin
               state_d = FETCH;
               cause_d = 2'd0;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   assign trap_cause_o    = cause_q;
   assign current_state_o = state_q;
   assign instret_o       = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: per-cycle vector table plus timeout, wrap and reset sequences.
module tb_multicycle_ctrl_fsm;

   localparam int CNT_W = 4;

   localparam logic [6:0] ADDI   = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] OPR    = 7'b0110011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] SYSTEM = 7'b1110011;
   localparam logic [6:0] ILLEGL = 7'b0000000;

   localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_T = 3'd5;

   // {imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, retire, trap}
   localparam logic [7:0] O_F  = 8'b1000_0000;
   localparam logic [7:0] O_FI = 8'b1001_0000;
   localparam logic [7:0] O_0  = 8'b0000_0000;
   localparam logic [7:0] O_WB = 8'b0000_1110;
   localparam logic [7:0] O_ML = 8'b0100_0000;
   localparam logic [7:0] O_SD = 8'b0110_1010;
   localparam logic [7:0] O_BR = 8'b0000_1010;
   localparam logic [7:0] O_T  = 8'b0000_0001;

   typedef struct packed {
      logic       stall;
      logic       imr;
      logic       dmr;
      logic       tclr;
      logic [6:0] op;
      logic       mul;
      logic [2:0] st;
      logic [7:0] outs;
      logic [1:0] cause;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [6:0]       opcode = '0;
   logic             is_mul = 1'b0;
   logic             imem_req, imem_ready = 1'b0;
   logic             dmem_req, dmem_we, dmem_ready = 1'b0;
   logic             stall = 1'b0, trap_clear = 1'b0;
   logic             ir_we, pc_we, rf_we, retire, trap;
   logic [1:0]       trap_cause;
   logic [2:0]       current_state;
   logic [CNT_W-1:0] instret;

   int n_tests = 0;
   int n_fail  = 0;
   int total   = 0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   multicycle_ctrl_fsm #(
      .EXEC_CYCLES(1), .MUL_CYCLES(4), .MEM_TIMEOUT(16), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .opcode_i(opcode), .is_mul_i(is_mul),
      .imem_req_o(imem_req), .imem_ready_i(imem_ready),
      .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_ready_i(dmem_ready),
      .stall_i(stall), .trap_clear_i(trap_clear),
      .ir_we_o(ir_we), .pc_we_o(pc_we), .rf_we_o(rf_we), .retire_o(retire),
      .trap_o(trap), .trap_cause_o(trap_cause), .current_state_o(current_state),
      .instret_o(instret)
   );

   function automatic vec_t v(input logic s, input logic ir, input logic dr, input logic tc,
                              input logic [6:0] op, input logic m, input logic [2:0] st,
                              input logic [7:0] o, input logic [1:0] c);
      vec_t r;
      r.stall = s; r.imr = ir; r.dmr = dr; r.tclr = tc; r.op = op; r.mul = m;
      r.st = st; r.outs = o; r.cause = c;
      return r;
   endfunction

   function automatic logic [7:0] outs_now();
      return {imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, retire, trap};
   endfunction

   task automatic check(input string name, input int id, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %0h expected %0h", name, id, got, exp);
      end
   endtask

   task automatic step(input vec_t x, input int id);
      logic [CNT_W-1:0] exp_cnt;
      @(negedge clk);
      stall = x.stall; imem_ready = x.imr; dmem_ready = x.dmr; trap_clear = x.tclr;
      opcode = x.op; is_mul = x.mul;
      #1;
      exp_cnt = CNT_W'(total);
      check("state", id, 32'(current_state), 32'(x.st));
      check("outs", id, 32'(outs_now()), 32'(x.outs));
      check("instret", id, 32'(instret), 32'(exp_cnt));
      if (x.st == S_T) check("cause", id, 32'(trap_cause), 32'(x.cause));
      if (x.outs[1]) total++;
   endtask

   task automatic run_addi(input int id);
      step(v(0,1,0,0,ADDI,0,S_F,O_FI,0), id);
      step(v(0,0,0,0,ADDI,0,S_D,O_0,0), id);
      step(v(0,0,0,0,ADDI,0,S_E,O_0,0), id);
      step(v(0,0,0,0,ADDI,0,S_W,O_WB,0), id);
   endtask

   initial begin
      // ADDI: F D E W
      tbl.push_back(v(0,1,0,0,ADDI,0,S_F,O_FI,0));
      tbl.push_back(v(0,0,0,0,ADDI,0,S_D,O_0,0));
      tbl.push_back(v(0,0,0,0,ADDI,0,S_E,O_0,0));
      tbl.push_back(v(0,0,0,0,ADDI,0,S_W,O_WB,0));
      // LOAD with three dmem wait cycles
      tbl.push_back(v(0,1,0,0,LOAD,0,S_F,O_FI,0));
      tbl.push_back(v(0,0,0,0,LOAD,0,S_D,O_0,0));
      tbl.push_back(v(0,0,0,0,LOAD,0,S_E,O_0,0));
      tbl.push_back(v(0,0,0,0,LOAD,0,S_M,O_ML,0));
      tbl.push_back(v(0,0,0,0,LOAD,0,S_M,O_ML,0));
      tbl.push_back(v(0,0,0,0,LOAD,0,S_M,O_ML,0));
      tbl.push_back(v(0,0,1,0,LOAD,0,S_M,O_ML,0));
      tbl.push_back(v(0,0,0,0,LOAD,0,S_W,O_WB,0));
      // STORE retires straight from MEMORY
      tbl.push_back(v(0,1,0,0,STORE,0,S_F,O_FI,0));
      tbl.push_back(v(0,0,0,0,STORE,0,S_D,O_0,0));
      tbl.push_back(v(0,0,0,0,STORE,0,S_E,O_0,0));
      tbl.push_back(v(0,0,1,0,STORE,0,S_M,O_SD,0));
      // MUL: four EXECUTE cycles
      tbl.push_back(v(0,1,0,0,OPR,1,S_F,O_FI,0));
      tbl.push_back(v(0,0,0,0,OPR,1,S_D,O_0,0));
      for (int i = 0; i < 4; i++) tbl.push_back(v(0,0,0,0,OPR,1,S_E,O_0,0));
      tbl.push_back(v(0,0,0,0,OPR,1,S_W,O_WB,0));
      // BRANCH retires from EXECUTE
      tbl.push_back(v(0,1,0,0,BRANCH,0,S_F,O_FI,0));
      tbl.push_back(v(0,0,0,0,BRANCH,0,S_D,O_0,0));
      tbl.push_back(v(0,0,0,0,BRANCH,0,S_E,O_BR,0));
      // illegal opcode and SYSTEM traps; second clear arrives under stall
      tbl.push_back(v(0,1,0,0,ILLEGL,0,S_F,O_FI,0));
      tbl.push_back(v(0,0,0,0,ILLEGL,0,S_D,O_0,0));
      tbl.push_back(v(0,0,0,0,ILLEGL,0,S_T,O_T,0));
      tbl.push_back(v(0,0,0,1,ILLEGL,0,S_T,O_T,0));
      tbl.push_back(v(0,1,0,0,SYSTEM,0,S_F,O_FI,0));
      tbl.push_back(v(0,0,0,0,SYSTEM,0,S_D,O_0,0));
      tbl.push_back(v(1,0,0,1,SYSTEM,0,S_T,O_T,1));
      // MUL with five stall cycles mid-EXECUTE, then stall in WRITEBACK
      tbl.push_back(v(0,1,0,0,OPR,1,S_F,O_FI,0));
      tbl.push_back(v(0,0,0,0,OPR,1,S_D,O_0,0));
      tbl.push_back(v(0,0,0,0,OPR,1,S_E,O_0,0));
      tbl.push_back(v(0,0,0,0,OPR,1,S_E,O_0,0));
      for (int i = 0; i < 5; i++) tbl.push_back(v(1,1,1,0,OPR,1,S_E,O_0,0));
      tbl.push_back(v(0,0,0,0,OPR,1,S_E,O_0,0));
      tbl.push_back(v(0,0,0,0,OPR,1,S_E,O_0,0));
      tbl.push_back(v(1,0,0,0,OPR,1,S_W,O_0,0));
      tbl.push_back(v(0,0,0,0,OPR,1,S_W,O_WB,0));
      // ready ignored under stall in FETCH and MEMORY
      tbl.push_back(v(1,1,0,0,LOAD,0,S_F,O_F,0));
      tbl.push_back(v(0,1,0,0,LOAD,0,S_F,O_FI,0));
      tbl.push_back(v(0,0,0,0,LOAD,0,S_D,O_0,0));
      tbl.push_back(v(0,0,0,0,LOAD,0,S_E,O_0,0));
      tbl.push_back(v(1,0,1,0,LOAD,0,S_M,O_ML,0));
      tbl.push_back(v(0,0,1,0,LOAD,0,S_M,O_ML,0));
      tbl.push_back(v(0,0,0,0,LOAD,0,S_W,O_WB,0));

      // reset state
      @(negedge clk); #1;
      check("rst_state", 0, 32'(current_state), 32'(S_F));
      check("rst_outs", 0, 32'(outs_now()), 32'(O_F));
      check("rst_instret", 0, 32'(instret), 32'd0);
      check("rst_cause", 0, 32'(trap_cause), 32'd0);
      @(negedge clk); rst_n = 1'b1;

      foreach (tbl[i]) step(tbl[i], i);

      // fetch timeout: 16 idle FETCH cycles then TRAP cause 2
      for (int i = 0; i < 16; i++) step(v(0,0,0,0,ADDI,0,S_F,O_F,0), 100 + i);
      step(v(0,0,0,0,ADDI,0,S_T,O_T,2), 116);
      step(v(0,0,0,1,ADDI,0,S_T,O_T,2), 117);

      // ready on the 16th cycle wins over the timeout
      for (int i = 0; i < 15; i++) step(v(0,0,0,0,ADDI,0,S_F,O_F,0), 200 + i);
      run_addi(215);

      // instret wraps at 2^CNT_W
      begin
         int n;
         n = 16 - total;
         for (int i = 0; i < n; i++) run_addi(300 + i);
      end
      step(v(0,0,0,0,ADDI,0,S_F,O_F,0), 320);
      check("wrap", 320, 32'(instret), 32'd0);

      // async reset in the middle of a LOAD
      step(v(0,1,0,0,LOAD,0,S_F,O_FI,0), 400);
      step(v(0,0,0,0,LOAD,0,S_D,O_0,0), 401);
      step(v(0,0,0,0,LOAD,0,S_E,O_0,0), 402);
      step(v(0,0,0,0,LOAD,0,S_M,O_ML,0), 403);
      @(negedge clk); dmem_ready = 1'b1; #2 rst_n = 1'b0; #1;
      total = 0;
      check("arst_state", 404, 32'(current_state), 32'(S_F));
      check("arst_outs", 404, 32'(outs_now()), 32'(O_F));
      check("arst_instret", 404, 32'(instret), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      run_addi(405);
      step(v(0,0,0,0,ADDI,0,S_F,O_F,0), 406);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
